// File: rtl/alu_result_pkg.sv
// Shared widths, entry layout and helpers for the ALU result queue.
package alu_result_pkg;

   localparam int unsigned ALU_DATA_W       = 32;
   localparam int unsigned ALU_RESULT_DEPTH = 4;
   localparam int unsigned ENTRY_W          = ALU_DATA_W + 2;

   typedef struct packed {
      logic [ALU_DATA_W-1:0] data;
      logic                  balance;
      logic                  equality;
   } alu_entry_t;

   // Saturating 16-bit increment used by the optional statistics counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/alu_result_mem.sv
// Register-array storage for the result queue: one synchronous write port,
// one asynchronous read port, contents cleared by asynchronous reset.
module alu_result_mem
   import alu_result_pkg::*;
#(
   parameter int unsigned DEPTH = ALU_RESULT_DEPTH,
   parameter int unsigned WIDTH = ENTRY_W,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_result_queue.sv
// First-word-fall-through queue for ALU results with occupancy, sticky overflow
// and, with ALU_RESULT_STATS_EN defined, a saturating equality-hit counter.
module alu_result_queue
   import alu_result_pkg::*;
#(
   parameter int unsigned DEPTH  = ALU_RESULT_DEPTH,
   parameter int unsigned DATA_W = ALU_DATA_W,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              captureValid,
   output logic              captureReady,
   input  logic [DATA_W-1:0] conclusion,
   input  logic              balancebit,
   input  logic              equalityBit,
   output logic              outValid,
   input  logic              outReady,
   output logic [DATA_W-1:0] outData,
   output logic              outBalance,
   output logic              outEquality,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   input  logic              clearOverflow
`ifdef ALU_RESULT_STATS_EN
   ,
   output logic [15:0]       eqCount
`endif
);

   localparam int unsigned EW = DATA_W + 2;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          push, pop, drop;
   logic [EW-1:0] wr_entry, rd_entry;

   // Status depends on registered occupancy only, so outReady never reaches
   // captureReady combinationally.
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign captureReady = !full;
   assign outValid     = !empty;
   assign count        = count_q;
   assign overflow     = overflow_q;

   assign push = captureValid && captureReady;
   assign drop = captureValid && !captureReady;
   assign pop  = outValid && outReady;

   assign wr_entry = {conclusion, balancebit, equalityBit};

   alu_result_mem #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_mem (
      .clock (clock),
      .reset (reset),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (wr_entry),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   assign outData     = rd_entry[EW-1:2];
   assign outBalance  = rd_entry[1];
   assign outEquality = rd_entry[0];

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      // DEPTH is a power of two, so natural pointer rollover is the wrap.
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (drop) begin
         overflow_d = 1'b1;
      end else if (clearOverflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef ALU_RESULT_STATS_EN
   logic [15:0] eq_count_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         eq_count_q <= '0;
      end else if (push && equalityBit) begin
         eq_count_q <= sat_inc16(eq_count_q);
      end
   end

   assign eqCount = eq_count_q;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed and randomized bench for alu_result_queue against a queue-based model.
module tb_alu_result_queue;
   import alu_result_pkg::*;

   localparam int unsigned DEPTH = ALU_RESULT_DEPTH;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        capture_valid = 1'b0;
   logic        capture_ready;
   logic [31:0] conclusion = '0;
   logic        balancebit = 1'b0;
   logic        equality_bit = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_balance;
   logic        out_equality;
   logic [2:0]  count;
   logic        full;
   logic        empty;
   logic        overflow;
   logic        clear_overflow = 1'b0;
`ifdef ALU_RESULT_STATS_EN
   logic [15:0] eq_count;
`endif

   alu_result_queue #(
      .DEPTH  (DEPTH),
      .DATA_W (ALU_DATA_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .captureValid  (capture_valid),
      .captureReady  (capture_ready),
      .conclusion    (conclusion),
      .balancebit    (balancebit),
      .equalityBit   (equality_bit),
      .outValid      (out_valid),
      .outReady      (out_ready),
      .outData       (out_data),
      .outBalance    (out_balance),
      .outEquality   (out_equality),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .overflow      (overflow),
      .clearOverflow (clear_overflow)
`ifdef ALU_RESULT_STATS_EN
      ,
      .eqCount       (eq_count)
`endif
   );

   always #5 clock = ~clock;

   // Reference model: ordered list of held results plus sticky flag and counter.
   alu_entry_t m_q[$];
   bit         m_ovf;
   int         m_eqc;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = m_q.size();
      check({tag, ":count"}, 32'(count), 32'(sz));
      check({tag, ":empty"}, 32'(empty), 32'(sz == 0));
      check({tag, ":full"}, 32'(full), 32'(sz == int'(DEPTH)));
      check({tag, ":outValid"}, 32'(out_valid), 32'(sz != 0));
      check({tag, ":captureReady"}, 32'(capture_ready), 32'(sz != int'(DEPTH)));
      check({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
      if (sz != 0) begin
         check({tag, ":outData"}, out_data, m_q[0].data);
         check({tag, ":outBalance"}, 32'(out_balance), 32'(m_q[0].balance));
         check({tag, ":outEquality"}, 32'(out_equality), 32'(m_q[0].equality));
      end
`ifdef ALU_RESULT_STATS_EN
      check({tag, ":eqCount"}, 32'(eq_count), 32'(m_eqc));
`endif
   endtask

   // One clock cycle: drive inputs, advance the model across the edge, check.
   task automatic step(input string tag, input bit cv, input logic [31:0] d, input bit b,
                       input bit e, input bit rdy, input bit clr);
      alu_entry_t ent;
      bit         acc;
      bit         pp;
      capture_valid  = cv;
      conclusion     = d;
      balancebit     = b;
      equality_bit   = e;
      out_ready      = rdy;
      clear_overflow = clr;
      acc = cv && (m_q.size() < int'(DEPTH));
      pp  = rdy && (m_q.size() > 0);
      @(posedge clock);
      if (pp) void'(m_q.pop_front());
      if (acc) begin
         ent.data     = d;
         ent.balance  = b;
         ent.equality = e;
         m_q.push_back(ent);
         if (e && m_eqc < 65535) m_eqc++;
      end
      if (cv && !acc) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse away from any clock edge; checked before the next edge.
   task automatic do_reset(input string tag);
      capture_valid  = 1'b0;
      out_ready      = 1'b0;
      clear_overflow = 1'b0;
      reset = 1'b1;
      #2;
      m_q.delete();
      m_ovf = 1'b0;
      m_eqc = 0;
      check_all(tag);
      check({tag, ":outData0"}, out_data, 32'd0);
      check({tag, ":outBalance0"}, 32'(out_balance), 32'd0);
      check({tag, ":outEquality0"}, 32'(out_equality), 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      do_reset("reset_init");

      // Ordering
      step("order_push", 1, 32'd101, 1, 0, 0, 0);
      step("order_push", 1, 32'd100, 0, 1, 0, 0);
      step("order_push", 1, 32'd7, 1, 1, 0, 0);
      check("order_count3", 32'(count), 32'd3);
      check("order_head101", out_data, 32'd101);
      step("order_drain", 0, 32'd0, 0, 0, 1, 0);
      check("order_head100", out_data, 32'd100);
      step("order_drain", 0, 32'd0, 0, 0, 1, 0);
      check("order_head7", out_data, 32'd7);
      step("order_drain", 0, 32'd0, 0, 0, 1, 0);
      check("order_empty", 32'(empty), 32'd1);

      // Overflow: fifth push is dropped
      for (int i = 1; i <= 5; i++) step("ovf_push", 1, 32'(i), 0, 0, 0, 0);
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         check("ovf_drain_order", out_data, 32'(i));
         step("ovf_drain", 0, 32'd0, 0, 0, 1, 0);
      end
      step("ovf_clear", 0, 32'd0, 0, 0, 0, 1);
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Wrap: steady push+pop at occupancy 2
      step("wrap_fill", 1, 32'hA0, 1, 0, 0, 0);
      step("wrap_fill", 1, 32'hA1, 0, 1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step("wrap_stream", 1, $urandom, 1'($urandom), 1'($urandom), 1, 0);
         check("wrap_count2", 32'(count), 32'd2);
      end

      // Full boundary: push+pop at count 4 pops but drops the push
      step("fb_fill", 1, 32'hB0, 0, 0, 0, 0);
      step("fb_fill", 1, 32'hB1, 0, 0, 0, 0);
      check("fb_count4", 32'(count), 32'd4);
      step("fb_pushpop", 1, 32'hBAD, 1, 1, 1, 0);
      check("fb_count3", 32'(count), 32'd3);
      check("fb_overflow", 32'(overflow), 32'd1);

      // Clear and drop in the same cycle: set wins
      step("set_wins_fill", 1, 32'hC0, 0, 0, 0, 0);
      step("set_wins", 1, 32'hC1, 0, 1, 0, 1);
      check("set_wins_ovf", 32'(overflow), 32'd1);

      // Push+pop while empty: push accepted, nothing popped
      do_reset("reset_pre_empty");
      step("empty_pushpop", 1, 32'hD0, 1, 0, 1, 0);
      check("empty_pushpop_count", 32'(count), 32'd1);
      step("empty_drain", 0, 32'd0, 0, 0, 1, 0);
      step("empty_pop", 0, 32'd0, 0, 0, 1, 0);

      // Stats: three accepted equality hits, one dropped
      do_reset("reset_pre_stats");
      for (int i = 0; i < 3; i++) step("stats_eq", 1, 32'(i + 16), 0, 1, 0, 0);
      step("stats_fill", 1, 32'h55, 0, 0, 0, 0);
      step("stats_drop", 1, 32'h66, 0, 1, 0, 0);
`ifdef ALU_RESULT_STATS_EN
      check("stats_eqcount3", 32'(eq_count), 32'd3);
`endif

      // Reset mid-stream with three entries queued
      do_reset("reset_pre_mid");
      for (int i = 0; i < 3; i++) step("mid_push", 1, $urandom, 1'($urandom), 1'($urandom), 0, 0);
      check("mid_count3", 32'(count), 32'd3);
      do_reset("reset_mid");
      step("post_reset_push", 1, 32'hE0, 1, 1, 0, 0);
      check("post_reset_count1", 32'(count), 32'd1);

      // Randomized traffic with drifting consumer pressure
      for (int i = 0; i < 400; i++) begin
         int unsigned rdy_pct;
         rdy_pct = ((i / 50) % 2 == 0) ? 30 : 80;
         step("rand", $urandom_range(0, 3) != 0, $urandom, 1'($urandom), 1'($urandom),
              $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 15) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
